// File: rtl/mem_arbiter.sv
// Single-port memory arbiter and pipeline stall controller: shares one memory port
// between instruction fetch and the MEM-stage load/store path, data access first.
module mem_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_data_o,
    output logic              if_valid_o,
    input  logic              d_read_i,
    input  logic              d_write_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              d_valid_o,
    output logic              stall_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i,
    output logic              err_o
);

    localparam bit         TO_EN   = (TIMEOUT != 0);
    localparam int         TO_LIM  = TO_EN ? TIMEOUT - 1 : 0;
    // Abort fires at the edge that would move the counter from TIMEOUT-1 to TIMEOUT.
    localparam logic [7:0] TO_LAST = 8'(TO_LIM);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_FETCH = 2'd2
    } state_t;

    state_t            state_r, state_s;
    logic [7:0]        wait_cnt_r, wait_cnt_s;
    logic              if_done_r, if_done_s;
    logic              d_done_r, d_done_s;
    logic              err_r, err_s;
    logic              mem_req_r, mem_req_s;
    logic              mem_we_r, mem_we_s;
    logic [ADDR_W-1:0] mem_addr_r, mem_addr_s;
    logic [DATA_W-1:0] mem_wdata_r, mem_wdata_s;
    logic [DATA_W-1:0] if_data_r, if_data_s;
    logic [DATA_W-1:0] d_rdata_r, d_rdata_s;

    logic d_req_s;
    logic stall_s;
    logic ack_s;
    logic timeout_s;

    assign d_req_s   = d_read_i | d_write_i;
    assign stall_s   = (if_req_i & ~if_done_r) | (d_req_s & ~d_done_r);
    assign ack_s     = mem_ack_i & mem_req_r;
    assign timeout_s = TO_EN && (wait_cnt_r == TO_LAST) && !ack_s;

    // Next-state and next-output computation for the access sequencer.
    always_comb begin
        state_s     = state_r;
        wait_cnt_s  = wait_cnt_r;
        if_done_s   = if_done_r;
        d_done_s    = d_done_r;
        err_s       = err_r;
        mem_req_s   = mem_req_r;
        mem_we_s    = mem_we_r;
        mem_addr_s  = mem_addr_r;
        mem_wdata_s = mem_wdata_r;
        if_data_s   = if_data_r;
        d_rdata_s   = d_rdata_r;
        case (state_r)
            ST_IDLE: begin
                wait_cnt_s = 8'd0;
                if (d_req_s && !d_done_r) begin
                    state_s     = ST_DATA;
                    mem_req_s   = 1'b1;
                    mem_we_s    = d_write_i;
                    mem_addr_s  = d_addr_i;
                    mem_wdata_s = d_wdata_i;
                end else if (if_req_i && !if_done_r) begin
                    state_s     = ST_FETCH;
                    mem_req_s   = 1'b1;
                    mem_we_s    = 1'b0;
                    mem_addr_s  = if_addr_i;
                    mem_wdata_s = {DATA_W{1'b0}};
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (ack_s) begin
                    state_s   = ST_IDLE;
                    mem_req_s = 1'b0;
                    d_rdata_s = mem_we_r ? d_rdata_r : mem_rdata_i;
                    // A request withdrawn mid-access was flushed; its result is dropped.
                    d_done_s  = d_req_s ? 1'b1 : d_done_r;
                end else if (timeout_s) begin
                    state_s   = ST_IDLE;
                    mem_req_s = 1'b0;
                    d_rdata_s = mem_we_r ? d_rdata_r : {DATA_W{1'b0}};
                    d_done_s  = 1'b1;
                    err_s     = 1'b1;
                end else begin
                    wait_cnt_s = wait_cnt_r + 8'd1;
                end
            end
            ST_FETCH: begin
                if (ack_s) begin
                    state_s   = ST_IDLE;
                    mem_req_s = 1'b0;
                    if_data_s = mem_rdata_i;
                    if_done_s = if_req_i ? 1'b1 : if_done_r;
                end else if (timeout_s) begin
                    state_s   = ST_IDLE;
                    mem_req_s = 1'b0;
                    if_data_s = {DATA_W{1'b0}};
                    if_done_s = 1'b1;
                    err_s     = 1'b1;
                end else begin
                    wait_cnt_s = wait_cnt_r + 8'd1;
                end
            end
            default: begin
                state_s   = ST_IDLE;
                mem_req_s = 1'b0;
            end
        endcase
        // The pipeline advances on this edge, so both results have been consumed.
        if_done_s = stall_s ? if_done_s : 1'b0;
        d_done_s  = stall_s ? d_done_s : 1'b0;
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_r     <= ST_IDLE;
            wait_cnt_r  <= 8'd0;
            if_done_r   <= 1'b0;
            d_done_r    <= 1'b0;
            err_r       <= 1'b0;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= {DATA_W{1'b0}};
            if_data_r   <= {DATA_W{1'b0}};
            d_rdata_r   <= {DATA_W{1'b0}};
        end else begin
            state_r     <= state_s;
            wait_cnt_r  <= wait_cnt_s;
            if_done_r   <= if_done_s;
            d_done_r    <= d_done_s;
            err_r       <= err_s;
            mem_req_r   <= mem_req_s;
            mem_we_r    <= mem_we_s;
            mem_addr_r  <= mem_addr_s;
            mem_wdata_r <= mem_wdata_s;
            if_data_r   <= if_data_s;
            d_rdata_r   <= d_rdata_s;
        end
    end

    assign if_data_o   = if_data_r;
    assign if_valid_o  = if_done_r;
    assign d_rdata_o   = d_rdata_r;
    assign d_valid_o   = d_done_r;
    assign stall_o     = stall_s;
    assign mem_req_o   = mem_req_r;
    assign mem_we_o    = mem_we_r;
    assign mem_addr_o  = mem_addr_r;
    assign mem_wdata_o = mem_wdata_r;
    assign err_o       = err_r;

endmodule
